// File: rtl/sensor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sensor_ctrl
//  Purpose  : Measurement scheduler and result filter around sensor_core.
//             Fires a measurement every PERIOD_CYC cycles and waits for
//             completion, with a timeout. Keeps a 4-sample moving average
//             of good echo counts and presents each result on a
//             valid/ready port.
//  Ports    : clk_sys, rst_n (async, active-low)
//             enable                          - allow periodic measurement
//             fire_measure                    - 1-cycle start pulse to core
//             done_measure/data_measure/err_measure - core completion
//             out_valid/out_ready/out_data/out_err/out_fill - result port
//             overrun                         - sticky lost-result flag
//  Revision : 1.0 - initial release
// ============================================================================
module sensor_ctrl #(
    parameter int unsigned PERIOD_CYC  = 3000000,  // must exceed TIMEOUT_CYC + 8
    parameter int unsigned TIMEOUT_CYC = 2400000
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        enable,
    output logic        fire_measure,
    input  logic        done_measure,
    input  logic [31:0] data_measure,
    input  logic        err_measure,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_err,
    output logic [2:0]  out_fill,
    output logic        overrun
);

    localparam int unsigned PW = $clog2(PERIOD_CYC);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    localparam logic [PW-1:0] C_PERIOD_LAST  = PW'(PERIOD_CYC - 1);
    localparam logic [TW-1:0] C_TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_period;
    logic [TW-1:0] r_timer;

    // Stage 1: measurement outcome registered at the end of the WAIT cycle
    logic          w_evt;
    logic          w_evt_good;
    logic          r_evt;
    logic          r_evt_good;
    logic [31:0]   r_evt_data;

    // Stage 2: averaging window and result registers
    logic [31:0]   r_win [4];       // r_win[3] is the oldest sample
    logic [33:0]   r_sum;
    logic [2:0]    r_fill;
    logic [31:0]   r_out_data;
    logic          r_out_valid;
    logic          r_out_err;
    logic          r_overrun;

    logic [2:0]    w_fill_nxt;
    logic [33:0]   w_sum_nxt;
    logic [40:0]   w_prod85;
    logic [31:0]   w_avg;

    // ------------------------------------------------------------------
    // Scheduler FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_evt       = 1'b0;
        w_evt_good  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_FIRE;
                end
            end
            ST_FIRE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion in the final timeout cycle still counts as a sample.
                if (done_measure) begin
                    w_evt       = 1'b1;
                    w_evt_good  = ~err_measure;
                    w_state_nxt = ST_GAP;
                end else if (r_timer == C_TIMEOUT_LAST) begin
                    w_evt       = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_period == C_PERIOD_LAST) begin
                    w_state_nxt = enable ? ST_FIRE : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign fire_measure = (r_state == ST_FIRE);

    // The FIRE cycle is period cycle 0, so the counter leaves FIRE at 1 and
    // GAP sees PERIOD_CYC-1 exactly PERIOD_CYC-1 cycles after the fire.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_period <= '0;
            r_timer  <= '0;
        end else begin
            if (r_state == ST_FIRE) begin
                r_period <= PW'(1);
            end else if (r_state != ST_IDLE) begin
                r_period <= r_period + PW'(1);
            end

            if (r_state == ST_FIRE) begin
                r_timer <= '0;
            end else if (r_state == ST_WAIT) begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_evt      <= 1'b0;
            r_evt_good <= 1'b0;
            r_evt_data <= '0;
        end else begin
            r_evt      <= w_evt;
            r_evt_good <= w_evt_good;
            if (w_evt_good) begin
                r_evt_data <= data_measure;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: running sum and average of the post-update window
    // ------------------------------------------------------------------
    always_comb begin
        w_fill_nxt = (r_fill == 3'd4) ? 3'd4 : r_fill + 3'd1;
        // Empty slots hold zero, so subtracting the oldest is always valid.
        w_sum_nxt  = r_sum + {2'b00, r_evt_data} - {2'b00, r_win[3]};
        // 85/256 approximates 1/3; truncation gives the floor of the product.
        w_prod85   = {7'd0, w_sum_nxt} * 41'd85;
        case (w_fill_nxt)
            3'd1:    w_avg = 32'(w_sum_nxt);
            3'd2:    w_avg = 32'(w_sum_nxt >> 1);
            3'd3:    w_avg = 32'(w_prod85 >> 8);
            default: w_avg = 32'(w_sum_nxt >> 2);
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_win[i] <= '0;
            end
            r_sum       <= '0;
            r_fill      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (r_evt) begin
                // A new result always loads; it is only lost data when the
                // pending one is not being taken this cycle.
                r_out_valid <= 1'b1;
                r_out_err   <= ~r_evt_good;
                if (r_out_valid && !out_ready) begin
                    r_overrun <= 1'b1;
                end
                if (r_evt_good) begin
                    r_win[0]   <= r_evt_data;
                    r_win[1]   <= r_win[0];
                    r_win[2]   <= r_win[1];
                    r_win[3]   <= r_win[2];
                    r_sum      <= w_sum_nxt;
                    r_fill     <= w_fill_nxt;
                    r_out_data <= w_avg;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;
    assign out_fill  = r_fill;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sensor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sensor_ctrl
//  Purpose  : Self-checking bench for sensor_ctrl with a short period and
//             timeout. Table vectors, random measurements against a
//             queue-based averaging model, and hand sequences for
//             backpressure, enable drop and reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_ctrl;

    localparam int PERIOD  = 400;
    localparam int TIMEOUT = 300;

    logic        clk_sys      = 1'b0;
    logic        rst_n        = 1'b0;
    logic        enable       = 1'b0;
    logic        done_measure = 1'b0;
    logic [31:0] data_measure = 32'd0;
    logic        err_measure  = 1'b0;
    logic        out_ready    = 1'b1;
    logic        fire_measure;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_err;
    logic [2:0]  out_fill;
    logic        overrun;

    sensor_ctrl #(
        .PERIOD_CYC  (PERIOD),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk_sys      (clk_sys),
        .rst_n        (rst_n),
        .enable       (enable),
        .fire_measure (fire_measure),
        .done_measure (done_measure),
        .data_measure (data_measure),
        .err_measure  (err_measure),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_err      (out_err),
        .out_fill     (out_fill),
        .overrun      (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int last_fire = -1;

    // Reference model: the last (up to) four good samples as a plain queue.
    logic [31:0] m_win [$];
    logic [31:0] m_avg = 32'd0;
    bit          m_ovr = 1'b0;

    typedef struct {
        int          dly;   // cycles after fire; > TIMEOUT means no response
        logic [31:0] data;
        bit          err;
        logic [31:0] xd;
        logic [2:0]  xf;
        bit          xe;
    } vec_t;

    vec_t tab [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_step(input bit good, input logic [31:0] d,
                                       output logic [31:0] xd, output logic [2:0] xf,
                                       output bit xe);
        longint unsigned s;
        if (good) begin
            m_win.push_back(d);
            if (m_win.size() > 4) void'(m_win.pop_front());
            s = 0;
            foreach (m_win[i]) s += longint'(m_win[i]);
            if (m_win.size() == 3) m_avg = 32'((s * 85) >> 8);
            else                   m_avg = 32'(s / longint'(m_win.size()));
        end
        xd = m_avg;
        xf = 3'(m_win.size());
        xe = !good;
    endfunction

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk_sys);
    endtask

    task automatic wait_fire(output int f);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < PERIOD + 10 && !seen; i++) begin
            if (fire_measure === 1'b1) seen = 1'b1;
            else @(negedge clk_sys);
        end
        f = cyc;
        chk("fire_seen", seen, 1);
        if (seen && last_fire >= 0) chk("fire_spacing", f - last_fire, PERIOD);
        last_fire = f;
    endtask

    task automatic do_meas(input int dly, input logic [31:0] d, input bit e,
                           input logic [31:0] xd, input logic [2:0] xf, input bit xe,
                           input bit pend, input int drop_at, output int f);
        int n;
        bit to;
        wait_fire(f);
        to = (dly > TIMEOUT);
        n  = to ? f + TIMEOUT : f + dly;
        if (drop_at > 0) begin
            goto(f + drop_at);
            enable = 1'b0;
        end
        if (!to) begin
            goto(n);
            done_measure = 1'b1;
            data_measure = d;
            err_measure  = e;
        end
        goto(n + 1);
        done_measure = 1'b0;
        err_measure  = 1'b0;
        data_measure = $urandom;
        chk("valid_before_latency", out_valid, pend);
        if (pend && !out_ready) m_ovr = 1'b1;
        goto(n + 2);
        chk("valid_at_latency", out_valid, 1);
        chk("out_data", out_data, xd);
        chk("out_fill", out_fill, xf);
        chk("out_err", out_err, xe);
        chk("overrun", overrun, m_ovr);
        goto(n + 3);
        chk("valid_after_edge", out_valid, !out_ready);
        if (to) begin
            // A completion arriving in GAP must be ignored.
            goto(f + TIMEOUT + 6);
            done_measure = 1'b1;
            data_measure = 32'hFFFF_0000;
            goto(f + TIMEOUT + 7);
            done_measure = 1'b0;
            goto(f + TIMEOUT + 10);
            chk("stray_done_valid", out_valid, 0);
            chk("stray_done_fill", out_fill, xf);
            chk("stray_done_data", out_data, xd);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          f;
        int          dly;
        int          cnt;
        logic [31:0] d;
        bit          e;
        logic [31:0] xd;
        logic [2:0]  xf;
        bit          xe;

        tab[0] = '{50,  32'd100,  1'b0, 32'd100, 3'd1, 1'b0};
        tab[1] = '{80,  32'd200,  1'b0, 32'd150, 3'd2, 1'b0};
        tab[2] = '{10,  32'd300,  1'b0, 32'd199, 3'd3, 1'b0};
        tab[3] = '{1,   32'd400,  1'b0, 32'd250, 3'd4, 1'b0};
        tab[4] = '{299, 32'd500,  1'b0, 32'd350, 3'd4, 1'b0};
        tab[5] = '{60,  32'd9999, 1'b1, 32'd350, 3'd4, 1'b1};  // core error
        tab[6] = '{999, 32'd0,    1'b0, 32'd350, 3'd4, 1'b1};  // timeout
        tab[7] = '{300, 32'd700,  1'b0, 32'd475, 3'd4, 1'b0};  // done beats timeout
        tab[8] = '{300, 32'd123,  1'b1, 32'd475, 3'd4, 1'b1};  // same, with error

        // Reset values
        repeat (3) @(negedge clk_sys);
        chk("rst_fire", fire_measure, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_fill", out_fill, 0);
        chk("rst_err", out_err, 0);
        chk("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        chk("idle_no_fire", fire_measure, 0);

        // First fire one cycle after enable is sampled
        enable = 1'b1;
        chk("fire_not_comb", fire_measure, 0);
        @(negedge clk_sys);
        chk("first_fire_latency", fire_measure, 1);

        // Table vectors: averaging, error, timeout, collisions
        for (int i = 0; i < 9; i++) begin
            model_step((tab[i].dly <= TIMEOUT) && !tab[i].err, tab[i].data, xd, xf, xe);
            do_meas(tab[i].dly, tab[i].data, tab[i].err,
                    tab[i].xd, tab[i].xf, tab[i].xe, 1'b0, 0, f);
        end

        // Random measurements against the model
        for (int i = 0; i < 24; i++) begin
            dly = int'($urandom_range(1, 330));
            d   = $urandom;
            e   = ($urandom_range(0, 3) == 0);
            model_step((dly <= TIMEOUT) && !e, d, xd, xf, xe);
            do_meas(dly, d, e, xd, xf, xe, 1'b0, 0, f);
        end

        // Backpressure: second result overwrites the first
        out_ready = 1'b0;
        model_step(1'b1, 32'd5000, xd, xf, xe);
        do_meas(40, 32'd5000, 1'b0, xd, xf, xe, 1'b0, 0, f);
        model_step(1'b1, 32'd6000, xd, xf, xe);
        do_meas(40, 32'd6000, 1'b0, xd, xf, xe, 1'b1, 0, f);
        out_ready = 1'b1;
        @(negedge clk_sys);
        chk("single_transfer", out_valid, 0);
        chk("overrun_sticky", overrun, 1);

        // Enable dropped mid-WAIT: result delivered, then no further fires
        model_step(1'b1, 32'd7000, xd, xf, xe);
        do_meas(100, 32'd7000, 1'b0, xd, xf, xe, 1'b0, 30, f);
        cnt = 0;
        while (cyc < f + 2 * PERIOD + 50) begin
            @(negedge clk_sys);
            if (fire_measure === 1'b1) cnt++;
        end
        chk("no_fire_after_disable", cnt, 0);
        last_fire = -1;

        // Reset asserted mid-GAP with a result pending
        out_ready = 1'b0;
        enable    = 1'b1;
        model_step(1'b1, 32'd8000, xd, xf, xe);
        do_meas(40, 32'd8000, 1'b0, xd, xf, xe, 1'b0, 0, f);
        goto(f + 200);
        rst_n = 1'b0;
        #1;
        chk("midrst_fire", fire_measure, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", out_data, 0);
        chk("midrst_fill", out_fill, 0);
        chk("midrst_err", out_err, 0);
        chk("midrst_overrun", overrun, 0);
        m_win.delete();
        m_avg     = 32'd0;
        m_ovr     = 1'b0;
        last_fire = -1;
        out_ready = 1'b1;
        @(negedge clk_sys);
        rst_n = 1'b1;

        // Basic cycle from an empty window, then a timeout with fire spacing
        model_step(1'b1, 32'd1000, xd, xf, xe);
        do_meas(50, 32'd1000, 1'b0, 32'd1000, 3'd1, 1'b0, 1'b0, 0, f);
        model_step(1'b0, 32'd0, xd, xf, xe);
        do_meas(999, 32'd0, 1'b0, 32'd1000, 3'd1, 1'b1, 1'b0, 0, f);
        wait_fire(f);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sensor_ctrl.md
# sensor_ctrl

Measurement scheduler and result filter placed directly upstream and downstream of `sensor_core`. It issues `fire_measure` pulses at a fixed period and watches for `done_measure`, with a timeout if it never comes. It captures `data_measure`, keeps a 4-sample moving average of good echo counts, and presents each result on a valid/ready output port to the system bus logic.

## Interface
- `PERIOD_CYC`, default 3000000: clk_sys cycles between consecutive `fire_measure` pulses. Must be greater than `TIMEOUT_CYC + 8`.
- `TIMEOUT_CYC`, default 2400000: maximum clk_sys cycles spent in WAIT before declaring a timeout.
- `clk_sys` input, 1 bit: system clock. All logic is on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `enable` input, 1 bit: level that allows periodic measurement.
- `fire_measure` output, 1 bit: one-cycle start pulse to `sensor_core`.
- `done_measure` input, 1 bit: one-cycle completion pulse from `sensor_core`.
- `data_measure` input, 32 bits: echo count. Valid in the cycle `done_measure` is high.
- `err_measure` input, 1 bit: core error flag, sampled with `done_measure`.
- `out_valid` output, 1 bit: result available.
- `out_ready` input, 1 bit: consumer accepts the result.
- `out_data` output, 32 bits: moving-average echo count.
- `out_err` output, 1 bit: result came from a timeout or a core error.
- `out_fill` output, 3 bits: number of good samples in the window, 0 to 4.
- `overrun` output, 1 bit: sticky flag, set when an unaccepted result is overwritten. Cleared only by reset.

## Operation
- State machine has four states: IDLE, FIRE, WAIT, GAP.
  - IDLE: if `enable`=1, go to FIRE.
  - FIRE: one cycle with `fire_measure`=1. Clear the period counter and the timeout timer. Go to WAIT.
  - WAIT: timer increments every cycle.
    - If `done_measure`=1, capture the sample and go to GAP.
    - Else if the timer reaches `TIMEOUT_CYC`-1, log a timeout and go to GAP.
  - GAP: when the period counter reaches `PERIOD_CYC`-1, go to FIRE if `enable`=1, otherwise go to IDLE.
- The period counter increments every cycle from FIRE through GAP, so the spacing between fires is exactly `PERIOD_CYC`.
- `done_measure` outside WAIT is ignored. No capture takes place and no result is produced.
- If `done_measure` and the timeout condition occur in the same cycle, `done_measure` wins.
- Deasserting `enable` in WAIT or GAP does not abort. The current measurement completes and its result is delivered, then the block returns to IDLE.
- Good sample (`done_measure`=1 and `err_measure`=0):
  - Shift it into the 4-deep window. The oldest sample is dropped.
  - `out_fill` saturates at 4.
  - Keep a 34-bit running sum: add the new sample, subtract the dropped one. Slots not yet filled count as 0.
  - `out_data` = sum / `out_fill`. Implement this as a right shift when fill is 1, 2 or 4. Fill 3 uses sum×85>>8, truncated.
  - `out_err`=0.
- Bad sample (timeout, or `err_measure`=1): the window is unchanged, `out_data` holds its previous value, and `out_err`=1.
- Output handshake:
  - `out_valid` stays high until a cycle with `out_valid`=1 and `out_ready`=1.
  - If a new result arrives while `out_valid`=1 and no transfer happens in that cycle, the result is overwritten and `overrun` is set.
  - A transfer and a new result in the same cycle: the new result loads and `out_valid` stays 1, with no overrun.

## Timing
- Reset values: state IDLE; `fire_measure`, `out_valid`, `out_err`, `overrun` = 0; `out_data` = 0; `out_fill` = 0; window and sum cleared.
- `fire_measure` is high in the cycle after `enable` is first sampled 1 in IDLE.
- Result latency:
  - `done_measure` high in cycle N: sample registered at the end of N, sum and average computed in N+1, `out_valid`=1 from cycle N+2.
  - Timeout detected in cycle N: `out_valid`=1 from cycle N+2.
- In the steady state with `enable`=1, `fire_measure` pulses are exactly `PERIOD_CYC` cycles apart.
- Reset asserted mid-operation clears everything immediately. After release, the block starts in IDLE with an empty window.
- There are no combinational paths from inputs to outputs.

## Test plan
- Test parameters: `PERIOD_CYC`=400, `TIMEOUT_CYC`=300.
- Basic cycle: `enable`=1, model answers 50 cycles after each fire with data 1000 -> first `fire_measure` 1 cycle after enable, `out_valid` 2 cycles after done, `out_data`=1000, `out_fill`=1, `out_err`=0. Next fire 400 cycles after the first.
- Averaging: good samples 100, 200, 300, 400, 500 -> `out_data` = 100, 150, 199, 250, 350; `out_fill` = 1, 2, 3, 4, 4.
- Timeout: model never responds -> `out_valid` 2 cycles after the 300th WAIT cycle, `out_err`=1, `out_data` unchanged, `out_fill` unchanged. The next fire is still at 400.
- Error and collision: `err_measure`=1 with done -> `out_err`=1 and the window is unchanged. Done in the same cycle as the timeout -> treated as a good sample.
- Backpressure: `out_ready`=0 across two results -> second result overwrites the first and `overrun`=1. Then `out_ready`=1 -> single transfer, `overrun` stays 1.
- Enable and reset: drop `enable` mid-WAIT -> the result is still delivered, then IDLE with no further fires. Assert `rst_n` low mid-GAP -> all outputs return to reset values at once.
